tdm_demux4: RTL and testbench

- Time-division demultiplexer: the receive-side counterpart of the team's 4:1 muxes.
- Accepts a single interleaved sample stream (slot 0,1,2,3,0,...) with a start-of-frame marker on slot 0.
- Routes each sample to one of four per-channel output holding registers, each with its own valid/ready handshake.
- Sits between a serial TDM link front-end and four independent channel consumers.

---
 rtl/tdm_demux4.sv | 103 ++++++++++
 tb/tb_tdm_demux4.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux4.sv
// rtl/tdm_demux4.sv - four-slot TDM demultiplexer with per-channel holding registers
module tdm_demux4 #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     din,
    input  logic                 din_valid,
    input  logic                 din_sof,
    output logic                 din_ready,
    output logic [4*WIDTH-1:0]   dout,
    output logic [3:0]           dout_valid,
    input  logic [3:0]           dout_ready,
    output logic [1:0]           slot,
    output logic                 in_sync,
    output logic                 frame_err,
    input  logic                 err_clr
);

    typedef enum logic [0:0] {
        HUNT = 1'b0,
        SYNC = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [1:0]               slot_q, slot_d;
    logic [3:0][WIDTH-1:0]    dout_q;
    logic [3:0]               ch_free;
    logic [3:0]               wr;
    logic                     err;
    logic                     accept;

    // A channel can take a new sample if it is empty or being drained this cycle.
    assign ch_free = ~dout_valid | dout_ready;

    always_comb begin
        if (state_q == SYNC) begin
            din_ready = ch_free[slot_q];
        end else begin
            din_ready = din_sof ? ch_free[0] : 1'b1;
        end
    end

    assign accept = din_valid & din_ready;

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        wr      = 4'b0000;
        err     = 1'b0;
        case (state_q)
            HUNT: begin
                if (accept && din_sof) begin
                    wr      = 4'b0001;
                    slot_d  = 2'd1;
                    state_d = SYNC;
                end
            end
            SYNC: begin
                if (accept) begin
                    // Legal only when the marker coincides exactly with slot 0.
                    if (din_sof != (slot_q == 2'd0)) begin
                        err     = 1'b1;
                        slot_d  = 2'd0;
                        state_d = HUNT;
                    end else begin
                        wr     = 4'b0001 << slot_q;
                        slot_d = slot_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = HUNT;
                slot_d  = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= HUNT;
            slot_q     <= 2'd0;
            dout_q     <= '0;
            dout_valid <= 4'b0000;
            frame_err  <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            for (int k = 0; k < 4; k++) begin
                if (wr[k]) begin
                    dout_q[k] <= din;
                end
            end
            dout_valid <= wr | (dout_valid & ~dout_ready);
            frame_err  <= err | (frame_err & ~err_clr);
        end
    end

    assign dout    = dout_q;
    assign slot    = slot_q;
    assign in_sync = (state_q == SYNC);

endmodule

// File: tb/tb_tdm_demux4.sv
// tb/tb_tdm_demux4.sv - directed scoreboard bench for tdm_demux4
module tb_tdm_demux4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  din;
    logic        din_valid;
    logic        din_sof;
    logic        din_ready;
    logic [31:0] dout;
    logic [3:0]  dout_valid;
    logic [3:0]  dout_ready;
    logic [1:0]  slot;
    logic        in_sync;
    logic        frame_err;
    logic        err_clr;

    int          total = 0;
    int          bad = 0;
    logic [7:0]  sb [4][$];
    logic [7:0]  exp_d;

    tdm_demux4 #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .din_sof    (din_sof),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .slot       (slot),
        .in_sync    (in_sync),
        .frame_err  (frame_err),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic sof, input int ch);
        din       = d;
        din_sof   = sof;
        din_valid = 1'b1;
        #1;
        chk("din_ready", 32'(din_ready), 32'd1);
        if (ch >= 0) sb[ch].push_back(d);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        din_valid = 1'b0;
        din_sof   = 1'b0;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rst_n && dout_valid[k] && dout_ready[k]) begin
                total++;
                assert (sb[k].size() != 0) else begin
                    bad++;
                    $error("FAIL unexpected_out ch%0d observed=%h expected=none", k, dout[k*8 +: 8]);
                end
                if (sb[k].size() != 0) begin
                    exp_d = sb[k].pop_front();
                    total++;
                    assert (dout[k*8 +: 8] === exp_d) else begin
                        bad++;
                        $error("FAIL dout_ch%0d observed=%h expected=%h", k, dout[k*8 +: 8], exp_d);
                    end
                end
            end
        end
    end

    initial begin
        rst_n      = 1'b0;
        din        = 8'h00;
        din_valid  = 1'b0;
        din_sof    = 1'b0;
        dout_ready = 4'hF;
        err_clr    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_slot", 32'(slot), 32'd0);
        chk("rst_in_sync", 32'(in_sync), 32'd0);
        chk("rst_dout_valid", 32'(dout_valid), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_dout", dout, 32'd0);
        rst_n = 1'b1;

        // two frames, everyone ready
        send(8'h10, 1'b1, 0);
        chk("sync_after_sof", 32'(in_sync), 32'd1);
        chk("slot_after_sof", 32'(slot), 32'd1);
        send(8'h11, 1'b0, 1);
        send(8'h12, 1'b0, 2);
        send(8'h13, 1'b0, 3);
        send(8'h14, 1'b1, 0);
        send(8'h15, 1'b0, 1);
        send(8'h16, 1'b0, 2);
        send(8'h17, 1'b0, 3);
        idle();
        chk("t1_frame_err", 32'(frame_err), 32'd0);
        chk("t1_slot_wrap", 32'(slot), 32'd0);
        chk("t1_in_sync", 32'(in_sync), 32'd1);

        // back to HUNT; unmarked beats are dropped
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        send(8'hAA, 1'b0, -1);
        send(8'hBB, 1'b0, -1);
        chk("hunt_drop_valid", 32'(dout_valid), 32'd0);
        chk("hunt_in_sync", 32'(in_sync), 32'd0);
        send(8'h01, 1'b1, 0);
        chk("hunt_lock_slot", 32'(slot), 32'd1);
        chk("hunt_lock_sync", 32'(in_sync), 32'd1);

        // marker at slot 2
        send(8'h02, 1'b0, 1);
        send(8'h55, 1'b1, -1);
        chk("err_frame_err", 32'(frame_err), 32'd1);
        chk("err_in_sync", 32'(in_sync), 32'd0);
        chk("err_slot", 32'(slot), 32'd0);
        chk("err_no_write", 32'(dout_valid), 32'd0);
        idle();
        chk("err_sticky", 32'(frame_err), 32'd1);
        err_clr = 1'b1;
        idle();
        err_clr = 1'b0;
        chk("err_cleared", 32'(frame_err), 32'd0);

        // error and clear in the same cycle
        send(8'h20, 1'b1, 0);
        err_clr = 1'b1;
        send(8'h21, 1'b1, -1);
        err_clr = 1'b0;
        chk("err_beats_clr", 32'(frame_err), 32'd1);
        err_clr = 1'b1;
        idle();
        err_clr = 1'b0;
        chk("err_cleared2", 32'(frame_err), 32'd0);

        // missing marker at slot 0
        send(8'h30, 1'b1, 0);
        send(8'h31, 1'b0, 1);
        send(8'h32, 1'b0, 2);
        send(8'h33, 1'b0, 3);
        send(8'h34, 1'b0, -1);
        chk("miss_frame_err", 32'(frame_err), 32'd1);
        chk("miss_in_sync", 32'(in_sync), 32'd0);
        err_clr = 1'b1;
        idle();
        err_clr = 1'b0;

        // head-of-line stall on channel 1
        dout_ready = 4'b1101;
        send(8'h40, 1'b1, 0);
        send(8'h41, 1'b0, 1);
        send(8'h42, 1'b0, 2);
        send(8'h43, 1'b0, 3);
        send(8'h44, 1'b1, 0);
        din       = 8'h45;
        din_sof   = 1'b0;
        din_valid = 1'b1;
        #1;
        chk("stall_ready", 32'(din_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("stall_slot", 32'(slot), 32'd1);
        chk("stall_ch1_valid", 32'(dout_valid[1]), 32'd1);
        chk("stall_ch1_hold", 32'(dout[15:8]), 32'h41);
        chk("stall_ch2_kept", 32'(dout[23:16]), 32'h42);
        dout_ready = 4'hF;
        send(8'h45, 1'b0, 1);
        chk("unstall_ch1_valid", 32'(dout_valid[1]), 32'd1);
        chk("unstall_ch1_data", 32'(dout[15:8]), 32'h45);

        // 64 back-to-back beats starting at slot 2
        for (int i = 0; i < 64; i++) begin
            send(8'(i) + 8'h80, ((i + 2) % 4) == 0, (i + 2) % 4);
        end
        idle();
        chk("stream_frame_err", 32'(frame_err), 32'd0);
        for (int k = 0; k < 4; k++) begin
            chk("sb_drained", 32'(sb[k].size()), 32'd0);
        end

        // asynchronous reset mid-frame with ch3 held
        dout_ready = 4'b0111;
        send(8'hC2, 1'b0, 2);
        send(8'hC3, 1'b0, 3);
        send(8'hC0, 1'b1, 0);
        send(8'hC1, 1'b0, 1);
        din_valid = 1'b0;
        chk("pre_rst_ch3", 32'(dout_valid[3]), 32'd1);
        chk("pre_rst_slot", 32'(slot), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(dout_valid), 32'd0);
        chk("arst_slot", 32'(slot), 32'd0);
        chk("arst_in_sync", 32'(in_sync), 32'd0);
        chk("arst_dout", dout, 32'd0);
        for (int k = 0; k < 4; k++) sb[k].delete();
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        dout_ready = 4'hF;
        idle();
        chk("post_rst_valid", 32'(dout_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
